// File: rtl/sha512_pkg.sv
// Shared definitions for the SHA-512 padder and the compression core's load side.
package sha512_pkg;

  typedef enum logic [2:0] {
    DATA   = 3'd0,
    PADW   = 3'd1,
    ZERO   = 3'd2,
    LEN_HI = 3'd3,
    LEN_LO = 3'd4
  } pad_state_t;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int LEN_WORD_IDX    = 14;
  localparam logic [63:0] PAD_WORD = 64'h8000_0000_0000_0000;

  // A byte count above 8 is a protocol violation and is handled as a full word.
  function automatic logic [3:0] clamp_bytes(input logic [3:0] nb);
    logic [3:0] res;
    if (nb > 4'd8) begin
      res = 4'd8;
    end else begin
      res = nb;
    end
    return res;
  endfunction

endpackage

// File: rtl/sha512_pad_mask.sv
// Final-word shaper: keeps the valid leading bytes, drops in the 0x80 marker
// right after them and zeroes whatever trails.
module sha512_pad_mask (
  input  logic [63:0] in_data,
  input  logic [3:0]  in_bytes,
  output logic [63:0] padded,
  output logic        full,
  output logic [3:0]  eff_bytes
);
  import sha512_pkg::*;

  logic [3:0] nb_s;

  assign nb_s      = clamp_bytes(in_bytes);
  assign eff_bytes = nb_s;
  assign full      = (nb_s == 4'd8);

  // Byte-by-byte select: message byte, marker byte, or zero fill (byte 0 is MSB).
  always_comb begin
    padded = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nb_s) begin
        padded[63-8*i -: 8] = in_data[63-8*i -: 8];
      end else if (4'(i) == nb_s) begin
        padded[63-8*i -: 8] = 8'h80;
      end else begin
        padded[63-8*i -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// SHA-512 message padder: streams 64-bit message words in and emits the padded
// message as 16-word blocks through a single registered output stage.
module sha512_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [3:0]  in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_first,
  output logic        out_block_end,
  output logic        out_msg_end,
  output logic        busy
);
  import sha512_pkg::*;

  localparam logic [3:0] LAST_IDX    = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [3:0] PRE_LEN_IDX = 4'(LEN_WORD_IDX - 1);

  pad_state_t       state_r, state_nx;
  logic [3:0]       widx_r, widx_nx;
  logic [LEN_W-1:0] len_r, len_nx;
  logic [63:0]      data_r, data_nx;
  logic             valid_r, valid_nx;
  logic             first_r, first_nx;
  logic             bend_r, bend_nx;
  logic             mend_r, mend_nx;
  logic             busy_r, busy_nx;

  logic             load_s;
  logic             accept_s;
  logic             emit_s;
  logic [63:0]      padded_s;
  logic             full_s;
  logic [3:0]       eff_s;
  logic [127:0]     len128_s;

  sha512_pad_mask u_mask (
    .in_data   (in_data),
    .in_bytes  (in_bytes),
    .padded    (padded_s),
    .full      (full_s),
    .eff_bytes (eff_s)
  );

  // The output stage can take a new word whenever it is empty or being drained.
  assign load_s   = !valid_r || out_ready;
  assign in_ready = rst_n && (state_r == DATA) && load_s;
  assign accept_s = in_valid && in_ready;
  assign len128_s = 128'(len_r);

  assign out_valid     = valid_r;
  assign out_data      = data_r;
  assign out_first     = first_r;
  assign out_block_end = bend_r;
  assign out_msg_end   = mend_r;
  assign busy          = busy_r;

  // Next-state, next-word and counter logic; everything advances only on a load.
  always_comb begin
    state_nx = state_r;
    widx_nx  = widx_r;
    len_nx   = len_r;
    data_nx  = data_r;
    valid_nx = valid_r;
    first_nx = first_r;
    bend_nx  = bend_r;
    mend_nx  = mend_r;
    busy_nx  = busy_r;
    emit_s   = 1'b0;

    // busy ends when the final length word leaves; a new accept below re-arms it
    if (valid_r && out_ready && mend_r) begin
      busy_nx = 1'b0;
    end else begin
      busy_nx = busy_r;
    end

    if (load_s) begin
      valid_nx = 1'b0;
      case (state_r)
        DATA: begin
          if (accept_s) begin
            emit_s  = 1'b1;
            busy_nx = 1'b1;
            if (in_last) begin
              data_nx = padded_s;
              len_nx  = len_r + LEN_W'({eff_s, 3'b000});
              if (full_s) begin
                state_nx = PADW;
              end else if (widx_r == PRE_LEN_IDX) begin
                state_nx = LEN_HI;
              end else begin
                state_nx = ZERO;
              end
            end else begin
              data_nx  = in_data;
              len_nx   = len_r + LEN_W'(64);
              state_nx = DATA;
            end
          end else begin
            emit_s   = 1'b0;
            state_nx = DATA;
          end
        end
        PADW: begin
          emit_s  = 1'b1;
          data_nx = PAD_WORD;
          if (widx_r == PRE_LEN_IDX) begin
            state_nx = LEN_HI;
          end else begin
            state_nx = ZERO;
          end
        end
        ZERO: begin
          emit_s  = 1'b1;
          data_nx = 64'h0;
          if (widx_r == PRE_LEN_IDX) begin
            state_nx = LEN_HI;
          end else begin
            state_nx = ZERO;
          end
        end
        LEN_HI: begin
          emit_s   = 1'b1;
          data_nx  = len128_s[127:64];
          state_nx = LEN_LO;
        end
        LEN_LO: begin
          emit_s   = 1'b1;
          data_nx  = len128_s[63:0];
          len_nx   = {LEN_W{1'b0}};
          state_nx = DATA;
        end
        default: begin
          emit_s   = 1'b0;
          state_nx = DATA;
        end
      endcase

      if (emit_s) begin
        valid_nx = 1'b1;
        first_nx = (widx_r == 4'd0);
        bend_nx  = (widx_r == LAST_IDX);
        mend_nx  = (state_r == LEN_LO);
        widx_nx  = widx_r + 4'd1;
      end else begin
        widx_nx  = widx_r;
      end
    end else begin
      state_nx = state_r;
    end
  end

  // State, counters and the output register, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= DATA;
      widx_r  <= 4'd0;
      len_r   <= {LEN_W{1'b0}};
      data_r  <= 64'h0;
      valid_r <= 1'b0;
      first_r <= 1'b0;
      bend_r  <= 1'b0;
      mend_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      widx_r  <= widx_nx;
      len_r   <= len_nx;
      data_r  <= data_nx;
      valid_r <= valid_nx;
      first_r <= first_nx;
      bend_r  <= bend_nx;
      mend_r  <= mend_nx;
      busy_r  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_sha512_padder.sv
// Self-checking bench for sha512_padder: a byte-level padding model fills a
// scoreboard queue that a negedge monitor drains against the DUT output.
module tb_sha512_padder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_bytes;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_first;
  logic        out_block_end;
  logic        out_msg_end;
  logic        busy;

  sha512_padder #(.LEN_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_bytes      (in_bytes),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_first     (out_first),
    .out_block_end (out_block_end),
    .out_msg_end   (out_msg_end),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  flags;  // {first, block_end, msg_end}
  } exp_t;

  typedef struct {
    int          nbytes;
    bit          bad_len;
    int          exp_words;
    logic [63:0] exp_len;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic [63:0] last_out = 64'h0;
  bit          rand_ready = 1'b0;
  bit          pad_phase = 1'b0;
  bit          mon_en = 1'b1;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [2:0]  prev_flags;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int i);
    return 8'((32'h61 + i) & 32'hff);
  endfunction

  // Reference padding: byte-level FIPS construction, then sliced into words.
  task automatic push_model(input int n);
    logic [7:0]   b[$];
    logic [127:0] bits;
    int           nw;
    for (int i = 0; i < n; i++) b.push_back(msg_byte(i));
    b.push_back(8'h80);
    while ((b.size() % 128) != 112) b.push_back(8'h00);
    bits = 128'(n) << 3;
    for (int i = 15; i >= 0; i--) b.push_back(bits[8*i +: 8]);
    nw = b.size() / 8;
    for (int w = 0; w < nw; w++) begin
      exp_t e;
      e.data = 64'h0;
      for (int k = 0; k < 8; k++) e.data = {e.data[55:0], b[8*w+k]};
      e.flags = {(w % 16) == 0, (w % 16) == 15, w == nw - 1};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check64("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_msg(input int n, input bit bad_len);
    int nw;
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      int          vb;
      logic [63:0] d;
      vb = (w == nw - 1) ? n - 8 * w : 8;
      d  = 64'h0;
      for (int k = 0; k < 8; k++) d = {d[55:0], (k < vb) ? msg_byte(8*w+k) : 8'hEE};
      in_valid = 1'b1;
      in_data  = d;
      in_last  = (w == nw - 1);
      in_bytes = (w == nw - 1) ? (bad_len ? 4'd13 : 4'(vb)) : 4'd0;
      wait_accept();
    end
    pad_phase = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget, input logic [63:0] exp_len);
    int c = 0;
    while (n_out < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check64("word_count", 64'(n_out), 64'(target));
    check64("len_word", last_out, exp_len);
    @(negedge clk);
    check64("busy_after_msg", 64'(busy), 64'd0);
    check64("valid_after_msg", 64'(out_valid), 64'd0);
  endtask

  // Downstream ready: always 1, or a fair coin flip during the back-pressure run.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  end

  // Monitor: scoreboard pop on handshake, stall stability, in_ready lockout.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        check64("stall_valid", 64'(out_valid), 64'd1);
        check64("stall_data", out_data, prev_data);
        check64("stall_flags", 64'({out_first, out_block_end, out_msg_end}), 64'(prev_flags));
      end
      if (pad_phase) begin
        check64("in_ready_lockout", 64'(in_ready && !(out_valid && out_ready && out_msg_end)), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check64("unexpected_word", out_data, 64'h0 - 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check64("out_data", out_data, e.data);
          check64("out_flags", 64'({out_first, out_block_end, out_msg_end}), 64'(e.flags));
        end
        n_out++;
        last_out = out_data;
        if (out_msg_end) pad_phase = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flags = {out_first, out_block_end, out_msg_end};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int start;
    vecs[0]  = '{3,   1'b0, 16, 64'h18};
    vecs[1]  = '{0,   1'b0, 16, 64'h0};
    vecs[2]  = '{112, 1'b0, 32, 64'h380};
    vecs[3]  = '{111, 1'b0, 16, 64'h378};
    vecs[4]  = '{8,   1'b0, 16, 64'h40};
    vecs[5]  = '{55,  1'b0, 16, 64'h1b8};
    vecs[6]  = '{56,  1'b0, 16, 64'h1c0};
    vecs[7]  = '{104, 1'b0, 16, 64'h340};
    vecs[8]  = '{119, 1'b0, 32, 64'h3b8};
    vecs[9]  = '{120, 1'b0, 32, 64'h3c0};
    vecs[10] = '{128, 1'b0, 32, 64'h400};
    vecs[11] = '{16,  1'b1, 16, 64'h80};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 64'h0;
    in_last  = 1'b0;
    in_bytes = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check64("rst_out_valid", 64'(out_valid), 64'd0);
    check64("rst_out_data", out_data, 64'h0);
    check64("rst_flags", 64'({out_first, out_block_end, out_msg_end}), 64'd0);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check64("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Table-driven messages, no back-pressure
    for (int v = 0; v < 12; v++) begin
      start = n_out;
      push_model(vecs[v].nbytes);
      send_msg(vecs[v].nbytes, vecs[v].bad_len);
      wait_words(start + vecs[v].exp_words, 400, vecs[v].exp_len);
      @(posedge clk);
      #1;
    end

    // Three back-to-back "abc" messages under random back-pressure
    rand_ready = 1'b1;
    start = n_out;
    for (int m = 0; m < 3; m++) begin
      push_model(3);
      send_msg(3, 1'b0);
    end
    rand_ready = 1'b0;
    wait_words(start + 48, 2000, 64'h18);
    @(posedge clk);
    #1;

    // Reset after five words of a long message, then a clean "abc"
    mon_en = 1'b0;
    for (int w = 0; w < 5; w++) begin
      in_valid = 1'b1;
      in_data  = {8{8'h5A}};
      in_last  = 1'b0;
      in_bytes = 4'd8;
      wait_accept();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    check64("midrst_out_valid", 64'(out_valid), 64'd0);
    check64("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    pad_phase = 1'b0;
    mon_en    = 1'b1;
    start = n_out;
    push_model(3);
    send_msg(3, 1'b0);
    wait_words(start + 16, 400, 64'h18);

    check64("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
